// File: rtl/collision_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// collision_scheduler_pkg
// Shared definitions for the frog/car collision scheduler:
//   - default geometry (coordinate width, tile edge, number of cars, index width)
//   - scheduler FSM state encoding
// No ports; imported by tile_overlap_check and collision_scheduler.
// -----------------------------------------------------------------------------
package collision_scheduler_pkg;

   localparam int DEF_NUM_CARS  = 4;
   localparam int DEF_COORD_W   = 10;
   localparam int DEF_TILE_SIZE = 32;
   localparam int DEF_IDX_W     = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SCAN   = 2'd1,
      ST_DRAIN  = 2'd2,
      ST_REPORT = 2'd3
   } sched_state_t;

endpackage

// File: rtl/collision_scheduler_tile_overlap_check.sv
// -----------------------------------------------------------------------------
// tile_overlap_check
// Registered frog/car overlap comparator with exactly one cycle of latency.
// The car index and a valid flag travel alongside the result.
//
// Build option:
//   COLLISION_FULL_BOX_EN defined   : full axis-aligned box overlap on X and Y
//   COLLISION_FULL_BOX_EN undefined : frog top-left corner inside the half-open
//                                     car box [car, car+TILE_SIZE) on X and Y
//
// Ports:
//   clk, rst          clock, synchronous active-high reset (valid only)
//   frog_x, frog_y    frog top-left position
//   car_x, car_y      car top-left position
//   car_vld, car_idx  presented car is valid / its index
//   hit_p1            registered overlap result
//   vld_p1, idx_p1    registered valid and index matching hit_p1
// -----------------------------------------------------------------------------
module tile_overlap_check
   import collision_scheduler_pkg::*;
#(
   parameter int COORD_W   = DEF_COORD_W,
   parameter int TILE_SIZE = DEF_TILE_SIZE,
   parameter int IDX_W     = DEF_IDX_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [COORD_W-1:0] frog_x,
   input  logic [COORD_W-1:0] frog_y,
   input  logic [COORD_W-1:0] car_x,
   input  logic [COORD_W-1:0] car_y,
   input  logic               car_vld,
   input  logic [IDX_W-1:0]   car_idx,
   output logic               hit_p1,
   output logic               vld_p1,
   output logic [IDX_W-1:0]   idx_p1
);

   localparam logic [COORD_W:0] TILE = (COORD_W+1)'(TILE_SIZE);

   // pos < base + TILE, with the sum one bit wider so a car near the right
   // or bottom edge of the coordinate space does not wrap to a small bound.
   function automatic logic below_bound(input logic [COORD_W-1:0] pos,
                                        input logic [COORD_W-1:0] base);
      logic [COORD_W:0] bound;
      bound = {1'b0, base} + TILE;
      return ({1'b0, pos} < bound);
   endfunction

   logic hit_p0;

   always_comb begin
`ifdef COLLISION_FULL_BOX_EN
      hit_p0 = below_bound(frog_x, car_x) && below_bound(car_x, frog_x) &&
               below_bound(frog_y, car_y) && below_bound(car_y, frog_y);
`else
      hit_p0 = (frog_x >= car_x) && below_bound(frog_x, car_x) &&
               (frog_y >= car_y) && below_bound(frog_y, car_y);
`endif
   end

   // ---- stage p0 -> p1 ----
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p1 <= 1'b0;
      end else begin
         vld_p1 <= car_vld;
      end
   end

   always_ff @(posedge clk) begin
      hit_p1 <= hit_p0;
      idx_p1 <= car_idx;
   end

endmodule

// File: rtl/collision_scheduler.sv
// -----------------------------------------------------------------------------
// collision_scheduler
// Time-multiplexes one registered frog/tile overlap comparator across NUM_CARS
// car positions. A frame-start pulse snapshots the frog position and scans each
// car once, lowest index first; one aggregated hit flag plus the lowest hitting
// car index are published per frame.
//
// Build option: COLLISION_FULL_BOX_EN selects the full box overlap test inside
// tile_overlap_check; timing and FSM are identical in both builds.
//
// Ports:
//   i_Clk, i_Rst    clock, synchronous active-high reset
//   i_Frame_Start   1-cycle pulse starting a scan (accepted only in IDLE)
//   i_Frog_X/Y      frog top-left position (snapshotted on accept)
//   i_Cars_X/Y      packed car positions, car k at [k*COORD_W +: COORD_W];
//                   sampled live, held stable by the caller during a scan
//   o_Busy          high during SCAN and DRAIN
//   o_Done          1-cycle pulse, o_Hit/o_Hit_Index valid
//   o_Hit           any car hit in the last completed scan
//   o_Hit_Index     lowest hitting car index, 0 when no hit
//   o_Overrun       sticky: frame start seen while not IDLE (cleared by reset)
// -----------------------------------------------------------------------------
module collision_scheduler
   import collision_scheduler_pkg::*;
#(
   parameter int NUM_CARS  = DEF_NUM_CARS,
   parameter int COORD_W   = DEF_COORD_W,
   parameter int TILE_SIZE = DEF_TILE_SIZE,
   parameter int IDX_W     = DEF_IDX_W
) (
   input  logic                        i_Clk,
   input  logic                        i_Rst,
   input  logic                        i_Frame_Start,
   input  logic [COORD_W-1:0]          i_Frog_X,
   input  logic [COORD_W-1:0]          i_Frog_Y,
   input  logic [NUM_CARS*COORD_W-1:0] i_Cars_X,
   input  logic [NUM_CARS*COORD_W-1:0] i_Cars_Y,
   output logic                        o_Busy,
   output logic                        o_Done,
   output logic                        o_Hit,
   output logic [IDX_W-1:0]            o_Hit_Index,
   output logic                        o_Overrun
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CARS - 1);

   sched_state_t state, state_nxt;

   logic               accept;
   logic               overrun_set;
   logic               car_vld;
   logic               report_load;

   logic [IDX_W-1:0]   index;
   logic [COORD_W-1:0] frog_x_p0;
   logic [COORD_W-1:0] frog_y_p0;
   logic [COORD_W-1:0] car_x_p0;
   logic [COORD_W-1:0] car_y_p0;

   logic               hit_p1;
   logic               vld_p1;
   logic [IDX_W-1:0]   idx_p1;

   logic               acc_hit, acc_hit_nxt;
   logic [IDX_W-1:0]   acc_idx, acc_idx_nxt;

   logic               rpt_hit;
   logic [IDX_W-1:0]   rpt_idx;
   logic               overrun;

   // FSM state register
   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // FSM next state and control strobes. A start seen in any non-IDLE state,
   // REPORT included, is dropped and flagged as an overrun.
   always_comb begin
      state_nxt   = state;
      o_Busy      = 1'b0;
      o_Done      = 1'b0;
      accept      = 1'b0;
      overrun_set = 1'b0;
      car_vld     = 1'b0;
      report_load = 1'b0;
      case (state)
         ST_IDLE: begin
            if (i_Frame_Start) begin
               accept    = 1'b1;
               state_nxt = ST_SCAN;
            end
         end
         ST_SCAN: begin
            o_Busy      = 1'b1;
            car_vld     = 1'b1;
            overrun_set = i_Frame_Start;
            if (index == LAST_IDX) begin
               state_nxt = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            o_Busy      = 1'b1;
            overrun_set = i_Frame_Start;
            report_load = 1'b1;
            state_nxt   = ST_REPORT;
         end
         ST_REPORT: begin
            o_Done      = 1'b1;
            overrun_set = i_Frame_Start;
            state_nxt   = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         index <= '0;
      end else if (accept) begin
         index <= '0;
      end else if ((state == ST_SCAN) && (index != LAST_IDX)) begin
         index <= index + 1'b1;
      end
   end

   always_ff @(posedge i_Clk) begin
      if (accept) begin
         frog_x_p0 <= i_Frog_X;
         frog_y_p0 <= i_Frog_Y;
      end
   end

   assign car_x_p0 = i_Cars_X[index*COORD_W +: COORD_W];
   assign car_y_p0 = i_Cars_Y[index*COORD_W +: COORD_W];

   // ---- stage p0 -> p1 (comparator) ----
   tile_overlap_check #(
      .COORD_W   (COORD_W),
      .TILE_SIZE (TILE_SIZE),
      .IDX_W     (IDX_W)
   ) u_check (
      .clk     (i_Clk),
      .rst     (i_Rst),
      .frog_x  (frog_x_p0),
      .frog_y  (frog_y_p0),
      .car_x   (car_x_p0),
      .car_y   (car_y_p0),
      .car_vld (car_vld),
      .car_idx (index),
      .hit_p1  (hit_p1),
      .vld_p1  (vld_p1),
      .idx_p1  (idx_p1)
   );

   // Only the first hit of a scan records its index; results arrive in
   // ascending index order, so that is the lowest hitting car.
   always_comb begin
      acc_hit_nxt = acc_hit;
      acc_idx_nxt = acc_idx;
      if (vld_p1 && hit_p1 && !acc_hit) begin
         acc_hit_nxt = 1'b1;
         acc_idx_nxt = idx_p1;
      end
   end

   // ---- stage p1 -> p2 (accumulate / publish) ----
   always_ff @(posedge i_Clk) begin
      if (i_Rst || accept) begin
         acc_hit <= 1'b0;
         acc_idx <= '0;
      end else begin
         acc_hit <= acc_hit_nxt;
         acc_idx <= acc_idx_nxt;
      end
   end

   // The last comparator result lands during DRAIN, so the published result
   // takes the merged value then and is stable throughout the o_Done cycle.
   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         rpt_hit <= 1'b0;
         rpt_idx <= '0;
      end else if (report_load) begin
         rpt_hit <= acc_hit_nxt;
         rpt_idx <= acc_hit_nxt ? acc_idx_nxt : '0;
      end
   end

   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         overrun <= 1'b0;
      end else if (overrun_set) begin
         overrun <= 1'b1;
      end
   end

   assign o_Hit       = rpt_hit;
   assign o_Hit_Index = rpt_idx;
   assign o_Overrun   = overrun;

endmodule

// File: tb/tb_collision_scheduler.sv
// -----------------------------------------------------------------------------
// tb_collision_scheduler
// Directed self-checking bench for collision_scheduler. Cycle T is the cycle
// in which i_Frame_Start is high; expected values are worked out by hand from
// the geometry of each vector. Works with COLLISION_FULL_BOX_EN on or off.
// -----------------------------------------------------------------------------
module tb_collision_scheduler;

   localparam int NUM_CARS = 4;
   localparam int COORD_W  = 10;
   localparam int TILE     = 32;
   localparam int IDX_W    = 4;

   logic                        clk = 1'b0;
   logic                        rst;
   logic                        frame_start;
   logic [COORD_W-1:0]          frog_x;
   logic [COORD_W-1:0]          frog_y;
   logic [NUM_CARS*COORD_W-1:0] cars_x;
   logic [NUM_CARS*COORD_W-1:0] cars_y;
   logic                        busy;
   logic                        done;
   logic                        hit;
   logic [IDX_W-1:0]            hit_index;
   logic                        overrun;

   int pass_cnt  = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   collision_scheduler #(
      .NUM_CARS  (NUM_CARS),
      .COORD_W   (COORD_W),
      .TILE_SIZE (TILE),
      .IDX_W     (IDX_W)
   ) dut (
      .i_Clk         (clk),
      .i_Rst         (rst),
      .i_Frame_Start (frame_start),
      .i_Frog_X      (frog_x),
      .i_Frog_Y      (frog_y),
      .i_Cars_X      (cars_x),
      .i_Cars_Y      (cars_y),
      .o_Busy        (busy),
      .o_Done        (done),
      .o_Hit         (hit),
      .o_Hit_Index   (hit_index),
      .o_Overrun     (overrun)
   );

   // Advance one cycle; inputs are driven and outputs sampled 1 ns after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_car(input int k, input logic [COORD_W-1:0] x,
                          input logic [COORD_W-1:0] y);
      cars_x[k*COORD_W +: COORD_W] = x;
      cars_y[k*COORD_W +: COORD_W] = y;
   endtask

   task automatic cars_far();
      for (int k = 0; k < NUM_CARS; k++) set_car(k, 10'd600, 10'd600);
   endtask

   // Pulse start for one cycle (T); returns in cycle T+1.
   task automatic pulse();
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
   endtask

   // From cycle T+1, wait (bounded) for o_Done; returns the offset from T.
   task automatic wait_done(output int lat);
      lat = 1;
      while (!done && lat < 20) begin
         step();
         lat++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      total_cnt++;
      if ({busy, done, hit, hit_index, overrun} !== 8'd0)
         $display("FAIL reset_outputs: busy,done,hit,idx,ovr=%b required 00000000",
                  {busy, done, hit, hit_index, overrun});
      else pass_cnt++;
      rst = 1'b0;
      step();
   endtask

   task automatic test_no_hit();
      frog_x = 10'd0;
      frog_y = 10'd0;
      for (int k = 0; k < NUM_CARS; k++) set_car(k, 10'd100, 10'd100);
      pulse();
      for (int k = 1; k <= 5; k++) begin
         total_cnt++;
         if ({busy, done} !== 2'b10)
            $display("FAIL no_hit_busy_T+%0d: busy,done=%b required 10", k, {busy, done});
         else pass_cnt++;
         step();
      end
      total_cnt++;
      if ({busy, done, hit, hit_index} !== {1'b0, 1'b1, 1'b0, 4'd0})
         $display("FAIL no_hit_done_T+6: busy,done,hit,idx=%b required 0100000",
                  {busy, done, hit, hit_index});
      else pass_cnt++;
      step();
      total_cnt++;
      if ({busy, done} !== 2'b00)
         $display("FAIL no_hit_idle_T+7: busy,done=%b required 00", {busy, done});
      else pass_cnt++;
   endtask

   task automatic test_priority();
      int lat;
      frog_x = 10'd200;
      frog_y = 10'd50;
      cars_far();
      set_car(1, 10'd190, 10'd40);
      set_car(3, 10'd195, 10'd45);
      pulse();
      wait_done(lat);
      total_cnt++;
      if (lat !== 6) $display("FAIL priority_latency: done at T+%0d required T+6", lat);
      else pass_cnt++;
      total_cnt++;
      if ({hit, hit_index} !== {1'b1, 4'd1})
         $display("FAIL priority_result: hit=%b idx=%0d required hit=1 idx=1", hit, hit_index);
      else pass_cnt++;
      step();
      total_cnt++;
      if ({done, hit, hit_index} !== {1'b0, 1'b1, 4'd1})
         $display("FAIL priority_hold: done=%b hit=%b idx=%0d required done=0 hit=1 idx=1",
                  done, hit, hit_index);
      else pass_cnt++;
   endtask

   task automatic test_edge();
      int lat;
      logic [COORD_W-1:0] fx [5];
      logic [COORD_W-1:0] fy [5];
      logic               eh [5];
      logic [IDX_W-1:0]   ei [5];
      fx = '{10'd331, 10'd332, 10'd300, 10'd300, 10'd1020};
      fy = '{10'd300, 10'd300, 10'd331, 10'd332, 10'd1020};
      eh = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      ei = '{4'd2, 4'd0, 4'd2, 4'd0, 4'd3};
      for (int v = 0; v < 5; v++) begin
         cars_far();
         if (v < 4) set_car(2, 10'd300, 10'd300);
         else       set_car(3, 10'd1010, 10'd1010);
         frog_x = fx[v];
         frog_y = fy[v];
         pulse();
         wait_done(lat);
         total_cnt++;
         if ({done, hit, hit_index} !== {1'b1, eh[v], ei[v]})
            $display("FAIL edge_vec%0d: done=%b hit=%b idx=%0d required done=1 hit=%b idx=%0d",
                     v, done, hit, hit_index, eh[v], ei[v]);
         else pass_cnt++;
         step();
      end
   endtask

   task automatic test_overrun();
      int lat;
      int dones;
      frog_x = 10'd0;
      frog_y = 10'd0;
      cars_far();
      total_cnt++;
      if (overrun !== 1'b0) $display("FAIL overrun_initial: overrun=%b required 0", overrun);
      else pass_cnt++;
      pulse();                 // T+1
      step();                  // T+2
      step();                  // T+3
      frame_start = 1'b1;
      step();                  // T+4
      frame_start = 1'b0;
      total_cnt++;
      if ({busy, overrun} !== 2'b11)
         $display("FAIL overrun_set: busy,overrun=%b required 11", {busy, overrun});
      else pass_cnt++;
      dones = 0;
      for (int k = 4; k <= 6; k++) begin
         if (done) dones++;
         if (k < 6) step();
      end
      total_cnt++;
      if (dones !== 1 || done !== 1'b1)
         $display("FAIL overrun_single_done: %0d dones, done@T+6=%b required 1 and 1", dones, done);
      else pass_cnt++;
      step();                  // T+7, IDLE
      pulse();
      total_cnt++;
      if (busy !== 1'b1) $display("FAIL overrun_restart_accept: busy=%b required 1", busy);
      else pass_cnt++;
      wait_done(lat);
      total_cnt++;
      if (lat !== 6 || overrun !== 1'b1)
         $display("FAIL overrun_restart_done: done at T+%0d overrun=%b required T+6 and 1", lat, overrun);
      else pass_cnt++;
      step();
      // Start in the REPORT cycle is refused and still flags an overrun.
      rst = 1'b1;
      step();
      rst = 1'b0;
      pulse();
      wait_done(lat);
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      total_cnt++;
      if ({busy, overrun} !== 2'b01)
         $display("FAIL overrun_report_cycle: busy,overrun=%b required 01", {busy, overrun});
      else pass_cnt++;
      dones = 0;
      for (int k = 0; k < 8; k++) begin
         if (done) dones++;
         step();
      end
      total_cnt++;
      if (dones !== 0) $display("FAIL overrun_report_no_scan: %0d dones required 0", dones);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid_scan();
      int lat;
      int dones;
      frog_x = 10'd200;
      frog_y = 10'd50;
      cars_far();
      set_car(1, 10'd190, 10'd40);
      set_car(3, 10'd195, 10'd45);
      pulse();
      wait_done(lat);
      step();                  // o_Hit=1 held, o_Overrun still set
      pulse();                 // T+1
      step();                  // T+2
      rst = 1'b1;              // high during T+3
      step();                  // T+3
      step();                  // T+4
      rst = 1'b0;
      total_cnt++;
      if ({busy, done, hit, hit_index, overrun} !== 8'd0)
         $display("FAIL midscan_reset_outputs: busy,done,hit,idx,ovr=%b required 00000000",
                  {busy, done, hit, hit_index, overrun});
      else pass_cnt++;
      dones = 0;
      for (int k = 0; k < 8; k++) begin
         if (done) dones++;
         step();
      end
      total_cnt++;
      if (dones !== 0) $display("FAIL midscan_no_done: %0d dones required 0", dones);
      else pass_cnt++;
      pulse();
      wait_done(lat);
      total_cnt++;
      if (lat !== 6 || {hit, hit_index} !== {1'b1, 4'd1})
         $display("FAIL midscan_fresh_scan: done T+%0d hit=%b idx=%0d required T+6 hit=1 idx=1",
                  lat, hit, hit_index);
      else pass_cnt++;
      step();
   endtask

   task automatic test_full_box();
      int lat;
      logic exp_hit;
`ifdef COLLISION_FULL_BOX_EN
      exp_hit = 1'b1;
`else
      exp_hit = 1'b0;
`endif
      frog_x = 10'd100;
      frog_y = 10'd100;
      cars_far();
      set_car(0, 10'd110, 10'd110);
      pulse();
      wait_done(lat);
      total_cnt++;
      if ({done, hit, hit_index} !== {1'b1, exp_hit, 4'd0})
         $display("FAIL full_box: done=%b hit=%b idx=%0d required done=1 hit=%b idx=0",
                  done, hit, hit_index, exp_hit);
      else pass_cnt++;
      step();
   endtask

   initial begin
      rst         = 1'b1;
      frame_start = 1'b0;
      frog_x      = '0;
      frog_y      = '0;
      cars_x      = '0;
      cars_y      = '0;
      test_reset();
      test_no_hit();
      test_priority();
      test_edge();
      test_overrun();
      test_reset_mid_scan();
      test_full_box();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
